// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory among loader, data and fetch masters.
// Fixed priority with a fetch anti-starvation promotion; one transaction in flight.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic            cpu_clk,
  input  logic            reset,
  input  logic [2:0]      m_valid,
  output logic [2:0]      m_ready,
  input  logic [2:0]      m_we,
  input  logic [3*AW-1:0] m_addr,
  input  logic [95:0]     m_wdata,
  input  logic [11:0]     m_be,
  output logic [2:0]      m_rsp_valid,
  output logic [31:0]     m_rsp_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [31:0]     mem_rdata,
  output logic            busy,
  output logic [1:0]      grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int FW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [FW-1:0] FW_MAX    = FW'(MAX_WAIT);

  state_t        state, state_next;
  logic [1:0]    grant;
  logic [CW-1:0] wait_cnt;
  logic [FW-1:0] fetch_wait;
  logic [1:0]    win;
  logic          win_valid;
  logic          accept;

  // Fetch jumps ahead of data once it has been refused MAX_WAIT cycles in a row
  always_comb begin
    win_valid = 1'b0;
    win       = 2'd0;
    if (m_valid[0]) begin
      win_valid = 1'b1;
      win       = 2'd0;
    end else if (m_valid[2] && (fetch_wait == FW_MAX)) begin
      win_valid = 1'b1;
      win       = 2'd2;
    end else if (m_valid[1]) begin
      win_valid = 1'b1;
      win       = 2'd1;
    end else if (m_valid[2]) begin
      win_valid = 1'b1;
      win       = 2'd2;
    end
  end

  // Gated by reset so no master sees an acceptance while reset is held
  assign accept  = (state == IDLE) && reset && win_valid;
  assign m_ready = accept ? (3'b001 << win) : 3'b000;

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign grant_id    = busy ? grant : 2'd3;
  assign m_rsp_valid = (state == RESP) ? (3'b001 << grant) : 3'b000;
  assign m_rsp_rdata = ((state == RESP) && !mem_we) ? mem_rdata : 32'd0;

  // The memory bus registers double as the latched request; they hold after ISSUE
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      grant      <= 2'd0;
      wait_cnt   <= '0;
      fetch_wait <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
    end else begin
      mem_en <= accept;
      if (accept) begin
        grant     <= win;
        mem_we    <= m_we[win];
        mem_addr  <= m_addr[int'(win)*AW +: AW];
        mem_wdata <= m_wdata[int'(win)*32 +: 32];
        mem_be    <= m_be[int'(win)*4 +: 4];
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (!m_valid[2] || m_ready[2])   fetch_wait <= '0;
      else if (fetch_wait != FW_MAX)   fetch_wait <= fetch_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (MEM_LAT=2/MAX_WAIT=8 and
// MEM_LAT=1/MAX_WAIT=3) checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;

  logic        cpu_clk = 1'b0;
  logic [1:0]  rst_n;
  logic [2:0]  m_valid [2];
  logic [2:0]  m_ready [2];
  logic [2:0]  m_we [2];
  logic [95:0] m_addr [2];
  logic [95:0] m_wdata [2];
  logic [11:0] m_be [2];
  logic [2:0]  m_rsp_valid [2];
  logic [31:0] m_rsp_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];
  logic [1:0]  grant_id [2];

  int checks = 0;
  int failures = 0;

  // Model state: acceptance cycle, idle-again cycle, owner and latched request
  int          acc [2];
  int          free_at [2];
  int          owner [2];
  int          fw [2];
  logic        r_we [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_be [2];
  logic [2:0]  hold [2];
  int          mem_t [2];
  logic [31:0] mem_a [2];
  int          rst_at [2];
  logic        rel [2];
  int          fetch_hits = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_port_arbiter #(.AW(32), .MEM_LAT(2), .MAX_WAIT(8)) dut0 (
    .cpu_clk(cpu_clk), .reset(rst_n[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_we(m_we[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_be(m_be[0]),
    .m_rsp_valid(m_rsp_valid[0]), .m_rsp_rdata(m_rsp_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant_id(grant_id[0])
  );

  mem_port_arbiter #(.AW(32), .MEM_LAT(1), .MAX_WAIT(3)) dut1 (
    .cpu_clk(cpu_clk), .reset(rst_n[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_we(m_we[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_be(m_be[1]),
    .m_rsp_valid(m_rsp_valid[1]), .m_rsp_rdata(m_rsp_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant_id(grant_id[1])
  );

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int maxWaitOf(input int k);
    return (k == 0) ? 8 : 3;
  endfunction

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic newRequest(input int k, input int i);
    int sel;
    sel = $urandom_range(0, 3);
    m_we[k][i]           = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    m_addr[k][i*32 +: 32]  = (sel == 0) ? 32'h100 : (sel == 1) ? 32'h40 : $urandom;
    m_wdata[k][i*32 +: 32] = (sel == 1) ? 32'h12345678 : $urandom;
    m_be[k][i*4 +: 4]      = (sel == 1) ? 4'b0011 : 4'($urandom_range(0, 15));
  endtask

  // Masters hold valid until accepted; cycles 400..599 stress starvation and back-to-back fetch
  task automatic applyStimulus(input int c);
    logic mode1, want;
    mode1 = (c >= 400) && (c < 600);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!hold[k][i]) begin
          if (mode1) want = (k == 0) ? (i != 0) : (i == 2);
          else       want = ($urandom_range(0, 2) == 0);
          if (want) begin
            hold[k][i] = 1'b1;
            newRequest(k, i);
          end
        end
        m_valid[k][i] = hold[k][i];
      end
      mem_rdata[k] = (c == mem_t[k] + latOf(k)) ? memData(mem_a[k]) : 32'hBAD0BAD0;
    end
  endtask

  task automatic modelCycle(input int k, input int c);
    int w;
    logic idle, een;
    logic [2:0] er, ersp;
    idle = (c >= free_at[k]);
    w = -1;
    if (idle) begin
      if (m_valid[k][0])                                   w = 0;
      else if (m_valid[k][2] && fw[k] == maxWaitOf(k))    w = 2;
      else if (m_valid[k][1])                              w = 1;
      else if (m_valid[k][2])                              w = 2;
    end
    er = 3'b000;
    if (w >= 0) er[w] = 1'b1;
    een = !idle && (c == acc[k] + 1);
    ersp = 3'b000;
    if (!idle && (c == acc[k] + 1 + latOf(k))) ersp[owner[k]] = 1'b1;

    checkOutput($sformatf("ready%0d", k), m_ready[k], er);
    checkOutput($sformatf("busy%0d", k), busy[k], !idle);
    checkOutput($sformatf("grantId%0d", k), grant_id[k], idle ? 2'd3 : 2'(owner[k]));
    checkOutput($sformatf("memEn%0d", k), mem_en[k], een);
    checkOutput($sformatf("rspValid%0d", k), m_rsp_valid[k], ersp);
    if (een) begin
      checkOutput($sformatf("memWe%0d", k), mem_we[k], r_we[k]);
      checkOutput($sformatf("memAddr%0d", k), mem_addr[k], r_addr[k]);
      checkOutput($sformatf("memWdata%0d", k), mem_wdata[k], r_wdata[k]);
      checkOutput($sformatf("memBe%0d", k), mem_be[k], r_be[k]);
    end
    if (ersp != 3'b000)
      checkOutput($sformatf("rspData%0d", k), m_rsp_rdata[k], r_we[k] ? 32'd0 : memData(r_addr[k]));

    if (mem_en[k]) begin
      mem_t[k] = c;
      mem_a[k] = mem_addr[k];
    end

    if (m_valid[k][2] && !er[2]) fw[k] = (fw[k] < maxWaitOf(k)) ? fw[k] + 1 : fw[k];
    else                         fw[k] = 0;

    if (w >= 0) begin
      acc[k]     = c;
      free_at[k] = c + 2 + latOf(k);
      owner[k]   = w;
      r_we[k]    = m_we[k][w];
      r_addr[k]  = m_addr[k][w*32 +: 32];
      r_wdata[k] = m_wdata[k][w*32 +: 32];
      r_be[k]    = m_be[k][w*4 +: 4];
      hold[k][w] = 1'b0;
      if (k == 0 && w == 2 && c >= 400 && c < 600) fetch_hits++;
    end

    // Drop reset in the cycle just before the response would appear
    if (c >= rst_at[k] && c < free_at[k] && c == acc[k] + latOf(k)) begin
      rst_n[k] = 1'b0;
      #1;
      checkOutput($sformatf("midRstRsp%0d", k), m_rsp_valid[k], 3'b000);
      checkOutput($sformatf("midRstBusy%0d", k), busy[k], 1'b0);
      checkOutput($sformatf("midRstGrant%0d", k), grant_id[k], 2'd3);
      checkOutput($sformatf("midRstReady%0d", k), m_ready[k], 3'b000);
      checkOutput($sformatf("midRstMemEn%0d", k), mem_en[k], 1'b0);
      free_at[k] = 0;
      fw[k]      = 0;
      rel[k]     = 1'b1;
      rst_at[k]  = c + 300;
    end
  endtask

  initial begin
    rst_n = 2'b00;
    for (int k = 0; k < 2; k++) begin
      hold[k]      = 3'b111;
      m_valid[k]   = 3'b111;
      for (int i = 0; i < 3; i++) newRequest(k, i);
      mem_rdata[k] = 32'hBAD0BAD0;
      free_at[k]   = 0;
      acc[k]       = -10;
      owner[k]     = 0;
      fw[k]        = 0;
      mem_t[k]     = -100;
      mem_a[k]     = 32'd0;
      rel[k]       = 1'b0;
      rst_at[k]    = (k == 0) ? 150 : 250;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rstReady%0d", k), m_ready[k], 3'b000);
      checkOutput($sformatf("rstMemEn%0d", k), mem_en[k], 1'b0);
      checkOutput($sformatf("rstMemWe%0d", k), mem_we[k], 1'b0);
      checkOutput($sformatf("rstGrant%0d", k), grant_id[k], 2'd3);
      checkOutput($sformatf("rstBusy%0d", k), busy[k], 1'b0);
      checkOutput($sformatf("rstRsp%0d", k), m_rsp_valid[k], 3'b000);
      checkOutput($sformatf("rstRdata%0d", k), m_rsp_rdata[k], 32'd0);
      checkOutput($sformatf("rstBus%0d", k), {mem_addr[k], mem_wdata[k]}, 64'd0);
      checkOutput($sformatf("rstBe%0d", k), mem_be[k], 4'd0);
    end
    @(posedge cpu_clk);
    @(posedge cpu_clk);
    for (int c = 0; c < 1000; c++) begin
      @(posedge cpu_clk);
      #1;
      if (c == 0) rst_n = 2'b11;
      for (int k = 0; k < 2; k++) begin
        if (rel[k]) begin
          rst_n[k] = 1'b1;
          rel[k]   = 1'b0;
        end
      end
      applyStimulus(c);
      #3;
      for (int k = 0; k < 2; k++) modelCycle(k, c);
    end
    checkOutput("fetchServed", 64'(fetch_hits > 0), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
